// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: buffers FPU requests in a small FIFO, issues them one at a
// time to the FPU with a single-cycle load strobe, waits for Done (with a
// settle cycle and a watchdog) and presents each result on a registered
// valid/ready output stream.
module fpu_issue_queue #(
  parameter int PRECISION = 32,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [PRECISION-1:0]     InA,
  input  logic [PRECISION-1:0]     InB,
  input  logic [1:0]               InOp,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [PRECISION-1:0]     OutResult,
  output logic [1:0]               OutOp,
  output logic                     OutErr,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [PRECISION-1:0]     FpuA,
  output logic [PRECISION-1:0]     FpuB,
  output logic [1:0]               FpuOperation,
  output logic                     FpuStart,
  input  logic [PRECISION-1:0]     FpuResult,
  input  logic                     FpuDone
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [PRECISION-1:0] a;
    logic [PRECISION-1:0] b;
    logic [1:0]           op;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_WAIT,
    S_HOLD
  } state_t;

  entry_t               mem [DEPTH];
  entry_t               in_entry;
  entry_t               cur_q, cur_d;
  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic                 out_valid_q, out_valid_d;
  logic [PRECISION-1:0] out_result_q, out_result_d;
  logic [1:0]           out_op_q, out_op_d;
  logic                 out_err_q, out_err_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;

  // A full FIFO refuses pushes regardless of a same-cycle pop (no bypass).
  assign InReady    = (count_q != CW'(DEPTH));
  assign push       = InValid && InReady;
  assign fifo_empty = (count_q == '0);
  assign in_entry   = '{a: InA, b: InB, op: InOp};

  // FIFO storage: written on push, no reset needed since pointers gate reads.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_entry;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Issue FSM: next state, pop decision, current-op capture and result capture.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    cur_d        = cur_q;
    wd_d         = wd_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;
    out_err_d    = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // Done may still be high from the previous op here, so it is ignored.
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WW'(1);
        if (FpuDone) begin
          out_valid_d  = 1'b1;
          out_result_d = FpuResult;
          out_op_d     = cur_q.op;
          out_err_d    = 1'b0;
          state_d      = S_HOLD;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          out_valid_d  = 1'b1;
          out_result_d = '0;
          out_op_d     = cur_q.op;
          out_err_d    = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (pop) begin
      cur_d = mem[rd_ptr_q];
    end
  end

  // State registers; reset discards every queued and in-flight op.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wd_q         <= '0;
      cur_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wd_q         <= wd_d;
      cur_q        <= cur_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
      out_err_q    <= out_err_d;
    end
  end

  assign Count        = count_q;
  assign OutValid     = out_valid_q;
  assign OutResult    = out_result_q;
  assign OutOp        = out_op_q;
  assign OutErr       = out_err_q;
  assign FpuA         = cur_q.a;
  assign FpuB         = cur_q.b;
  assign FpuOperation = cur_q.op;
  // Decoded straight from the state register, so it is high only in LOAD.
  assign FpuStart     = (state_q == S_LOAD);

endmodule
